alu_muldiv_seq: RTL

- Multi-cycle unsigned 8x8 multiply and 8/8 divide sequencer.
- It is the initiator side of the ALU operand/opcode interface. It drives data1, data2 and the ALU opcode, then consumes the ALU result and carry flag one step per clock.
- It sits beside the 8-bit ALU in the CPU datapath. The control unit uses it for MUL/DIV instructions so the ALU needs no native multiply or divide.

---
 rtl/alu_muldiv_seq_if.sv | 32 +++
 rtl/alu_muldiv_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq_if.sv
// ALU operand/opcode bus between the mul/div sequencer (master) and the 8-bit ALU (slave).
// The sequencer drives both operands and the opcode. The ALU returns its result and carry/borrow flag.

`ifndef ALUOP_ADD
`define ALUOP_ADD 4'h0
`endif
`ifndef ALUOP_SUB
`define ALUOP_SUB 4'h1
`endif
`ifndef ALUOP_PD1
`define ALUOP_PD1 4'hA
`endif

interface alu_muldiv_seq_if #(
    parameter int OP_W = 4
);
    logic [7:0]      o_ALUData1;
    logic [7:0]      o_ALUData2;
    logic [OP_W-1:0] o_ALUOp;
    logic [7:0]      i_ALUResult;
    logic            i_ALUC;

    modport master (
        output o_ALUData1, o_ALUData2, o_ALUOp,
        input  i_ALUResult, i_ALUC
    );

    modport slave (
        input  o_ALUData1, o_ALUData2, o_ALUOp,
        output i_ALUResult, i_ALUC
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned 8x8 multiply (shift-add) and 8/8 divide (restoring) sequencer.
// Each step uses the datapath ALU for one add or subtract. One step is taken per clock.
// The shared accumulator pair holds {ACC_HI,ACC_LO} for multiply and {R,Q} for divide.

`ifndef ALUOP_ADD
`define ALUOP_ADD 4'h0
`endif
`ifndef ALUOP_SUB
`define ALUOP_SUB 4'h1
`endif
`ifndef ALUOP_PD1
`define ALUOP_PD1 4'hA
`endif

module alu_muldiv_seq #(
    parameter int              OP_W    = 4,
    parameter logic [OP_W-1:0] IDLE_OP = OP_W'(`ALUOP_PD1)
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_Start,
    input  logic                    i_Op,
    input  logic [7:0]              i_A,
    input  logic [7:0]              i_B,
    output logic                    o_Busy,
    output logic                    o_Done,
    output logic [7:0]              o_ResultHi,
    output logic [7:0]              o_ResultLo,
    output logic                    o_DivZero,
    alu_muldiv_seq_if.master        alu
);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(`ALUOP_ADD);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(`ALUOP_SUB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e          state_q;
    logic [2:0]      step_q;
    logic [7:0]      acc_hi_q;     // ACC_HI (multiply) or R (divide)
    logic [7:0]      acc_lo_q;     // ACC_LO (multiply) or Q (divide)
    logic [7:0]      opb_q;        // M (multiply) or D (divide)
    logic [7:0]      res_hi_q;
    logic [7:0]      res_lo_q;
    logic            busy_q;
    logic            done_q;
    logic            divzero_q;

    logic [7:0]      acc_hi_d;
    logic [7:0]      acc_lo_d;
    logic [7:0]      rem_shift;    // Rs: remainder shifted left with the next dividend bit
    logic [OP_W-1:0] alu_op;
    logic [7:0]      alu_data1;
    logic [7:0]      alu_data2;

    // ALU drive and next accumulator value for the current step, derived from registered state.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rem_shift = {acc_hi_q[6:0], acc_lo_q[7]};
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        alu_op    = IDLE_OP;
        alu_data1 = 8'h00;
        alu_data2 = 8'h00;
        case (state_q)
            S_MUL: begin
                alu_op    = OP_ADD;
                alu_data1 = acc_hi_q;
                alu_data2 = acc_lo_q[0] ? opb_q : 8'h00;
                {acc_hi_d, acc_lo_d} = {alu.i_ALUC, alu.i_ALUResult, acc_lo_q[7:1]};
            end
            S_DIV: begin
                alu_op    = OP_SUB;
                alu_data1 = rem_shift;
                alu_data2 = opb_q;
                if (!alu.i_ALUC) begin
                    acc_hi_d = alu.i_ALUResult;
                    acc_lo_d = {acc_lo_q[6:0], 1'b1};
                end else begin
                    acc_hi_d = rem_shift;
                    acc_lo_d = {acc_lo_q[6:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    assign alu.o_ALUOp    = alu_op;
    assign alu.o_ALUData1 = alu_data1;
    assign alu.o_ALUData2 = alu_data2;

    // Sequencer FSM: accepts a start in IDLE and runs 8 ALU steps. DONE then raises the one-cycle o_Done.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q   <= S_IDLE;
            step_q    <= 3'd0;
            acc_hi_q  <= 8'h00;
            acc_lo_q  <= 8'h00;
            opb_q     <= 8'h00;
            res_hi_q  <= 8'h00;
            res_lo_q  <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_Start) begin
                        busy_q    <= 1'b1;
                        divzero_q <= 1'b0;
                        step_q    <= 3'd0;
                        acc_hi_q  <= 8'h00;
                        acc_lo_q  <= i_A;
                        opb_q     <= i_B;
                        if (i_Op && (i_B == 8'h00)) begin
                            // Divide by zero skips the ALU entirely.
                            res_hi_q  <= i_A;
                            res_lo_q  <= 8'hFF;
                            divzero_q <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            state_q <= i_Op ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    step_q   <= step_q + 3'd1;
                    if (step_q == 3'd7) begin
                        res_hi_q <= acc_hi_d;
                        res_lo_q <= acc_lo_d;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_Busy     = busy_q;
    assign o_Done     = done_q;
    assign o_ResultHi = res_hi_q;
    assign o_ResultLo = res_lo_q;
    assign o_DivZero  = divzero_q;

endmodule
